// File: rtl/bcd_a_siete_segmentos_if.sv
// Display-driver bus: the packed BCD value with its load strobe, plus the multiplexed
// segment, digit-enable and error outputs. The master drives the value, the slave drives the display.
interface bcd_a_siete_segmentos_if;
   logic [7:0] bcd_input;
   logic       load;
   logic [6:0] seg_output;
   logic [1:0] digit_enable;
   logic       bcd_error;

   modport master (
      output bcd_input, load,
      input  seg_output, digit_enable, bcd_error
   );

   modport slave (
      input  bcd_input, load,
      output seg_output, digit_enable, bcd_error
   );
endinterface

// File: rtl/bcd_a_siete_segmentos.sv
// Two-digit multiplexed common-anode 7-segment driver for a packed BCD value.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit while it is zero.
module bcd_a_siete_segmentos #(
   parameter int REFRESH_DIV = 50000
) (
   input logic                     clk,
   input logic                     rst,
   bcd_a_siete_segmentos_if.slave  bus
);

   typedef enum logic {SHOW_UNITS, SHOW_TENS} state_t;

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             tick;
   state_t           state;
   logic [7:0]       value;
   logic [3:0]       nibble;
   logic             blank;
   logic [6:0]       seg_next;
   logic [1:0]       en_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

   assign tick = (cnt == CNT_MAX);

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      blank    = 1'b0;
      nibble   = (state == SHOW_TENS) ? value[7:4] : value[3:0];
`ifdef LEADING_ZERO_BLANK_EN
      blank    = (state == SHOW_TENS) && (value[7:4] == 4'd0);
`else
      blank    = 1'b0;
`endif
      seg_next = blank ? 7'b1111111 : decode(nibble);
      en_next  = blank ? 2'b00 : ((state == SHOW_TENS) ? 2'b10 : 2'b01);
   end

   // Pins are driven from the current value/state, so a capture or a state change shows one edge later.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         value            <= 8'h00;
         cnt              <= '0;
         state            <= SHOW_UNITS;
         bus.seg_output   <= 7'b1111111;
         bus.digit_enable <= 2'b00;
         bus.bcd_error    <= 1'b0;
      end else begin
         if (bus.load)
            value <= bus.bcd_input;
         cnt <= tick ? '0 : cnt + 1'b1;
         case (state)
            SHOW_UNITS: if (tick) state <= SHOW_TENS;
            SHOW_TENS:  if (tick) state <= SHOW_UNITS;
            default:    state <= SHOW_UNITS;
         endcase
         bus.seg_output   <= seg_next;
         bus.digit_enable <= en_next;
         bus.bcd_error    <= (value[7:4] > 4'd9) | (value[3:0] > 4'd9);
      end
   end

endmodule

// File: tb/tb_bcd_a_siete_segmentos.sv
// Scoreboard bench: stimulus queues hand-computed pin values tagged with the clock edge
// after which they must appear; a negedge monitor pops and compares them.
module tb_bcd_a_siete_segmentos;

   localparam int REFRESH_DIV = 4;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] TENS0_SEG = SEG_OFF;
   localparam logic [1:0] TENS0_EN  = 2'b00;
`else
   localparam logic [6:0] TENS0_SEG = SEG_0;
   localparam logic [1:0] TENS0_EN  = 2'b10;
`endif

   typedef struct {
      int         cyc;
      logic [6:0] seg;
      logic [1:0] en;
      logic       err;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   edge_n = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   bcd_a_siete_segmentos_if bus ();

   bcd_a_siete_segmentos #(.REFRESH_DIV(REFRESH_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got seg=%b en=%b err=%b, required seg=%b en=%b err=%b",
                  name, edge_n, act[9:3], act[2:1], act[0], req[9:3], req[2:1], req[0]);
      end
   endtask

   task automatic expect_at(input int cyc, input logic [6:0] seg, input logic [1:0] en,
                            input logic err, input string name);
      exp_t e;
      int   i;
      e.cyc = cyc; e.seg = seg; e.en = en; e.err = err; e.name = name;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= cyc) i++;
      sb.insert(i, e);
   endtask

   // Monitor: outputs are stable at the falling edge after edge number edge_n.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
         exp_t e;
         e = sb.pop_front();
         if (e.cyc < edge_n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for edge %0d never sampled", e.name, e.cyc);
         end else begin
            check(e.name, {bus.seg_output, bus.digit_enable, bus.bcd_error},
                  {e.seg, e.en, e.err});
         end
      end
   end

   // Called at a falling edge; returns at a falling edge with rst low, next edge is the first run edge.
   task automatic do_reset();
      int b;
      b = edge_n;
      rst = 1'b1;
      bus.load = 1'b0;
      expect_at(b + 1, SEG_OFF, 2'b00, 1'b0, "reset_first");
      expect_at(b + 3, SEG_OFF, 2'b00, 1'b0, "reset_held");
      expect_at(b + 4, SEG_0, 2'b01, 1'b0, "release_units00");
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      bus.bcd_input = 8'h00;
      bus.load = 1'b0;
      @(negedge clk);

      // Load 0x15, watch both slots alternate every REFRESH_DIV edges
      do_reset();
      n = edge_n;
      bus.bcd_input = 8'h15; bus.load = 1'b1;
      expect_at(n + 2,  SEG_5, 2'b01, 1'b0, "h15_units_first");
      expect_at(n + 4,  SEG_5, 2'b01, 1'b0, "h15_units_last");
      expect_at(n + 5,  SEG_1, 2'b10, 1'b0, "h15_tens_first");
      expect_at(n + 8,  SEG_1, 2'b10, 1'b0, "h15_tens_last");
      expect_at(n + 9,  SEG_5, 2'b01, 1'b0, "h15_units_again");
      expect_at(n + 13, SEG_1, 2'b10, 1'b0, "h15_tens_again");
      @(negedge clk); bus.load = 1'b0;
      repeat (13) @(negedge clk);

      // Invalid nibble then recovery
      do_reset();
      n = edge_n;
      bus.bcd_input = 8'h0A; bus.load = 1'b1;
      expect_at(n + 2, SEG_DASH, 2'b01, 1'b1, "h0a_units_dash");
      expect_at(n + 3, SEG_DASH, 2'b01, 1'b1, "h0a_units_hold");
      expect_at(n + 4, SEG_9, 2'b01, 1'b0, "h09_units");
      expect_at(n + 5, TENS0_SEG, TENS0_EN, 1'b0, "h09_tens0");
      @(negedge clk); bus.load = 1'b0;
      @(negedge clk); bus.bcd_input = 8'h09; bus.load = 1'b1;
      @(negedge clk); bus.load = 1'b0;
      repeat (5) @(negedge clk);

      // Leading-zero tens slot
      do_reset();
      n = edge_n;
      bus.bcd_input = 8'h07; bus.load = 1'b1;
      expect_at(n + 2, SEG_7, 2'b01, 1'b0, "h07_units");
      expect_at(n + 5, TENS0_SEG, TENS0_EN, 1'b0, "h07_tens_first");
      expect_at(n + 8, TENS0_SEG, TENS0_EN, 1'b0, "h07_tens_last");
      expect_at(n + 9, SEG_7, 2'b01, 1'b0, "h07_units_again");
      @(negedge clk); bus.load = 1'b0;
      repeat (9) @(negedge clk);

      // Load exactly on the wrap edge (edge n+4)
      do_reset();
      n = edge_n;
      expect_at(n + 4, SEG_0, 2'b01, 1'b0, "pre_wrap_units00");
      expect_at(n + 5, SEG_4, 2'b10, 1'b0, "h42_tens_at_wrap");
      expect_at(n + 9, SEG_2, 2'b01, 1'b0, "h42_units");
      repeat (3) @(negedge clk);
      bus.bcd_input = 8'h42; bus.load = 1'b1;
      @(negedge clk); bus.load = 1'b0;
      repeat (7) @(negedge clk);

      // load held high: value tracks input every cycle
      do_reset();
      n = edge_n;
      bus.bcd_input = 8'h31; bus.load = 1'b1;
      expect_at(n + 2, SEG_1, 2'b01, 1'b0, "track_h31_units");
      expect_at(n + 3, SEG_6, 2'b01, 1'b0, "track_h26_units");
      @(negedge clk); bus.bcd_input = 8'h26;
      @(negedge clk); bus.load = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during the tens slot of 0x98
      do_reset();
      n = edge_n;
      bus.bcd_input = 8'h98; bus.load = 1'b1;
      expect_at(n + 2, SEG_8, 2'b01, 1'b0, "h98_units");
      expect_at(n + 5, SEG_9, 2'b10, 1'b0, "h98_tens");
      @(negedge clk); bus.load = 1'b0;
      repeat (5) @(negedge clk);
      do_reset();
      n = edge_n;
      expect_at(n + 2, SEG_0, 2'b01, 1'b0, "no_retain_units");
      expect_at(n + 5, TENS0_SEG, TENS0_EN, 1'b0, "no_retain_tens");
      repeat (6) @(negedge clk);

      // Bounded drain of anything still pending
      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: timed out waiting for edge %0d", e.name, e.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_a_siete_segmentos.md
# bcd_a_siete_segmentos

Two-digit multiplexed 7-segment display driver fed by the binary-to-BCD converter. Captures an 8-bit packed BCD value (tens in [7:4], units in [3:0]) on a load strobe and time-multiplexes both digits onto one shared segment bus using a refresh counter and a two-state digit-select machine. Invalid BCD nibbles show a dash and raise an error flag. Drives the board's common-anode displays directly.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit is held on the bus; legal range 2 .. 2^20.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bcd_input  input  8  packed BCD: [7:4] tens, [3:0] units.
- load  input  1  when high at a rising edge, bcd_input is captured into the internal value register.
- seg_output  output  7  {g,f,e,d,c,b,a}, active-low (0 = segment lit).
- digit_enable  output  2  one-hot, active-high: 2'b01 = units digit, 2'b10 = tens digit, 2'b00 = none.
- bcd_error  output  1  high while either captured nibble is greater than 9.

## Operation
- Value register (8 bits): loads bcd_input at every edge with load=1; otherwise holds. Cleared to 8'h00 by reset.
- Refresh counter: width $clog2(REFRESH_DIV), increments every cycle; at REFRESH_DIV-1 it wraps to 0 and raises an internal tick in the same edge.
- Digit-select FSM, two states:
  - SHOW_UNITS: on tick -> SHOW_TENS.
  - SHOW_TENS: on tick -> SHOW_UNITS.
  - Reset state: SHOW_UNITS.
- Segment decode of the selected nibble, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 10-15 = dash 0111111. Blank = 1111111.
- digit_enable = 2'b01 in SHOW_UNITS, 2'b10 in SHOW_TENS, subject to blanking (see Configuration).
- bcd_error = (value[7:4] > 9) | (value[3:0] > 9), registered.
- Outputs seg_output, digit_enable and bcd_error are all registered; no combinational path from any input to any output.

## Timing
- Reset values: seg_output=7'b1111111, digit_enable=2'b00, bcd_error=0, counter=0, FSM=SHOW_UNITS, value=8'h00.
- First cycle after rst deasserts: outputs update at the first edge to units digit of 8'h00 (seg_output=1000000, digit_enable=01).
- Load latency: load sampled at edge k -> value updated after k -> outputs reflect it at edge k+1 (one-cycle latency from capture to pins, bcd_error included).
- Digit period: each digit is held for exactly REFRESH_DIV cycles; state changes at the wrap edge, pins follow at the next edge.
- Load coinciding with a wrap edge: both take effect; pins at the next edge show the new digit of the new value.
- load held high continuously: value tracks bcd_input every cycle with one-cycle pin latency.
- rst mid-operation: overrides load and tick in the same edge; all state returns to reset values at that edge.
- digit_enable never has both bits high; switching from 01 to 10 happens in a single edge with no intermediate state.

## Configuration
- LEADING_ZERO_BLANK_EN defined: while in SHOW_TENS and value[7:4]==0, digit_enable=2'b00 and seg_output=1111111 for the whole tens slot; timing of the slot is unchanged. Tens nibble 1-15 unaffected.
- LEADING_ZERO_BLANK_EN undefined: tens digit 0 displays as 1000000 with digit_enable=2'b10.

## Test plan
(REFRESH_DIV=4 for simulation.)
- Reset: hold rst 3 cycles -> seg_output=1111111, digit_enable=00, bcd_error=0; release -> next edge seg_output=1000000, digit_enable=01.
- Load 8'h15 -> one edge later units slot shows 0010010 with 01; after 4 cycles tens slot shows 1111001 with 10; alternates every 4 cycles.
- Load 8'h0A -> bcd_error=1 one edge after capture, units slot shows 0111111; then load 8'h09 -> bcd_error=0, units 0010000.
- Load 8'h07 with macro defined -> tens slot digit_enable=00, seg_output=1111111; without macro -> tens slot 1000000 with 10.
- Load 8'h42 exactly at a wrap edge -> next edge shows tens digit 4 (0011001) with 10.
- Assert rst during tens slot with value 8'h98 -> next edge reset values; after release units of 8'h00 shown, value not retained.
